plic_claim_arbiter: RTL and testbench



---
 rtl/plic_claim_arbiter_pkg.sv | 20 ++
 rtl/plic_claim_arbiter_if.sv | 30 +++
 rtl/plic_claim_arbiter_gateway.sv | 37 +++
 rtl/plic_claim_arbiter.sv | 84 ++++++++
 tb/tb_plic_claim_arbiter.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/plic_claim_arbiter_pkg.sv
// Shared types and sizing for the PLIC claim arbiter slice.
package plic_pkg;

    localparam int NUM_SRC_DEF = 8;
    localparam int PRIO_W_DEF  = 3;

    // ID 0 is reserved for "none", so IDs need room for NUM_SRC+1 codes.
    function automatic int calc_id_w(input int num_src);
        return $clog2(num_src + 1);
    endfunction

    localparam int ID_W_DEF = calc_id_w(NUM_SRC_DEF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_SERV = 2'd2
    } gw_state_e;

endpackage

// File: rtl/plic_claim_arbiter_if.sv
// Request / claim / complete bundle between the sensing stage, register block and arbiter.
interface plic_claim_arbiter_if
    import plic_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int PRIO_W  = PRIO_W_DEF
);
    localparam int ID_W = calc_id_w(NUM_SRC);

    logic [NUM_SRC-1:0]        irq_req;
    logic [NUM_SRC*PRIO_W-1:0] prio;
    logic [PRIO_W-1:0]         threshold;
    logic                      claim_rd;
    logic [ID_W-1:0]           claim_id;
    logic                      complete_wr;
    logic [ID_W-1:0]           complete_id;
    logic [NUM_SRC-1:0]        pending;
    logic                      eip;

    modport master (
        output irq_req, prio, threshold, claim_rd, complete_wr, complete_id,
        input  claim_id, pending, eip
    );

    modport slave (
        input  irq_req, prio, threshold, claim_rd, complete_wr, complete_id,
        output claim_id, pending, eip
    );

endinterface

// File: rtl/plic_claim_arbiter_gateway.sv
// Per-source gateway: latches one request and holds it until claimed and completed.
module plic_gateway
    import plic_pkg::*;
(
    input  logic pclk,
    input  logic preset,
    input  logic irq_req,
    input  logic claim_hit,
    input  logic complete_hit,
    output logic pend,
    output logic in_serv
);

    gw_state_e state_q, state_d;

    always_ff @(posedge pclk) begin
        if (preset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Requests seen while pending or in service are absorbed, not counted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (irq_req)      state_d = S_PEND;
            S_PEND:  if (claim_hit)    state_d = S_SERV;
            S_SERV:  if (complete_hit) state_d = irq_req ? S_PEND : S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pend    = (state_q == S_PEND);
        in_serv = (state_q == S_SERV);
    end

endmodule

// File: rtl/plic_claim_arbiter.sv
// PLIC priority arbiter and claim/complete controller.
// Build option: PLIC_PRIORITY_EN enables priority arbitration and threshold masking.
module plic_claim_arbiter
    import plic_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int PRIO_W  = PRIO_W_DEF
) (
    input logic                 pclk,
    input logic                 preset,
    plic_claim_arbiter_if.slave bus
);

    localparam int ID_W = calc_id_w(NUM_SRC);

    logic [NUM_SRC-1:0] pend_vec;
    logic [NUM_SRC-1:0] serv_vec;
    logic [NUM_SRC-1:0] claim_hit;
    logic [NUM_SRC-1:0] complete_hit;
    logic [ID_W-1:0]    best_id;
    logic               eip_d;
    logic [ID_W-1:0]    claim_id_q;
    logic               eip_q;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
        assign claim_hit[g]    = bus.claim_rd && (best_id == ID_W'(g + 1));
        assign complete_hit[g] = bus.complete_wr && serv_vec[g] &&
                                 (bus.complete_id == ID_W'(g + 1));

        plic_gateway u_gw (
            .pclk         (pclk),
            .preset       (preset),
            .irq_req      (bus.irq_req[g]),
            .claim_hit    (claim_hit[g]),
            .complete_hit (complete_hit[g]),
            .pend         (pend_vec[g]),
            .in_serv      (serv_vec[g])
        );
    end

`ifdef PLIC_PRIORITY_EN
    logic [PRIO_W-1:0] best_prio;

    // Strict '>' from a zero start drops priority-0 sources and keeps the lowest index on ties.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pend_vec[i] && (bus.prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
                best_prio = bus.prio[i*PRIO_W +: PRIO_W];
                best_id   = ID_W'(i + 1);
            end
        end
        eip_d = (best_prio > bus.threshold) && (best_id != '0);
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{bus.prio, bus.threshold};

    always_comb begin
        best_id = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pend_vec[i] && (best_id == '0)) best_id = ID_W'(i + 1);
        end
        eip_d = |pend_vec;
    end
`endif

    // claim_id holds the last claim result until the next claim strobe.
    always_ff @(posedge pclk) begin
        if (preset) begin
            claim_id_q <= '0;
            eip_q      <= 1'b0;
        end else begin
            if (bus.claim_rd) claim_id_q <= best_id;
            eip_q <= eip_d;
        end
    end

    assign bus.claim_id = claim_id_q;
    assign bus.pending  = pend_vec;
    assign bus.eip      = eip_q;

endmodule

// File: tb/tb_plic_claim_arbiter.sv
// Self-checking bench for plic_claim_arbiter: vector table plus corner-case sequences.
`timescale 1ns/1ps
module tb_plic_claim_arbiter;
    import plic_pkg::*;

    localparam int NS = NUM_SRC_DEF;
    localparam int PW = PRIO_W_DEF;
    localparam int IW = calc_id_w(NS);

    typedef struct {
        logic          rst;
        logic [NS-1:0] irq;
        logic          clm;
        logic          cmp;
        logic [IW-1:0] cid;
        logic [PW-1:0] thr;
        logic [NS-1:0] e_pend;
        logic [IW-1:0] e_claim;
        logic          e_eip;
    } vec_t;

    logic pclk = 1'b0;
    logic preset;
    int   tests  = 0;
    int   failed = 0;
    int   vno    = 0;
    vec_t tbl[$];
    vec_t expq[$];

    always #5 pclk = ~pclk;

    plic_claim_arbiter_if #(.NUM_SRC(NS), .PRIO_W(PW)) bus ();

    plic_claim_arbiter #(.NUM_SRC(NS), .PRIO_W(PW)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    function automatic vec_t v(input logic rst, input logic [NS-1:0] irq, input logic clm,
                               input logic cmp, input logic [IW-1:0] cid, input logic [PW-1:0] thr,
                               input logic [NS-1:0] e_pend, input logic [IW-1:0] e_claim,
                               input logic e_eip);
        vec_t r;
        r.rst = rst; r.irq = irq; r.clm = clm; r.cmp = cmp; r.cid = cid; r.thr = thr;
        r.e_pend = e_pend; r.e_claim = e_claim; r.e_eip = e_eip;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s vec %0d: got %0h, want %0h", nm, vno, act, exp);
        end
    endtask

    // Drive one cycle of stimulus on the falling edge, check outputs just after the rising edge.
    task automatic step(input vec_t t);
        vec_t e;
        @(negedge pclk);
        preset          = t.rst;
        bus.irq_req     = t.irq;
        bus.claim_rd    = t.clm;
        bus.complete_wr = t.cmp;
        bus.complete_id = t.cid;
        bus.threshold   = t.thr;
        expq.push_back(t);
        @(posedge pclk);
        #1;
        e = expq.pop_front();
        chk("pending",  32'(bus.pending),  32'(e.e_pend));
        chk("claim_id", 32'(bus.claim_id), 32'(e.e_claim));
        chk("eip",      32'(bus.eip),      32'(e.e_eip));
        vno++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        preset          = 1'b1;
        bus.irq_req     = '0;
        bus.claim_rd    = 1'b0;
        bus.complete_wr = 1'b0;
        bus.complete_id = '0;
        bus.threshold   = '0;
        bus.prio        = {NS{PW'(1)}};

        // Equal priorities and zero threshold: both builds must behave as lowest-index-first.
        //          rst   irq    clm   cmp   cid    thr   pend   claim  eip
        tbl.push_back(v(1, 8'h00, 0, 0, 4'd0, 3'd0, 8'h00, 4'd0, 0));
        tbl.push_back(v(0, 8'h04, 0, 0, 4'd0, 3'd0, 8'h04, 4'd0, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 4'd0, 3'd0, 8'h04, 4'd0, 1));
        tbl.push_back(v(0, 8'h00, 1, 0, 4'd0, 3'd0, 8'h00, 4'd3, 1));
        tbl.push_back(v(0, 8'h00, 0, 0, 4'd0, 3'd0, 8'h00, 4'd3, 0));
        tbl.push_back(v(0, 8'h00, 0, 1, 4'd3, 3'd0, 8'h00, 4'd3, 0));
        tbl.push_back(v(0, 8'h04, 0, 0, 4'd0, 3'd0, 8'h04, 4'd3, 0));
        tbl.push_back(v(0, 8'h00, 1, 0, 4'd0, 3'd0, 8'h00, 4'd3, 1));
        tbl.push_back(v(0, 8'h04, 0, 0, 4'd0, 3'd0, 8'h00, 4'd3, 0));
        tbl.push_back(v(0, 8'h00, 0, 1, 4'd2, 3'd0, 8'h00, 4'd3, 0));
        tbl.push_back(v(0, 8'h00, 0, 1, 4'd0, 3'd0, 8'h00, 4'd3, 0));
        tbl.push_back(v(0, 8'h00, 0, 1, 4'd9, 3'd0, 8'h00, 4'd3, 0));
        tbl.push_back(v(0, 8'h04, 0, 1, 4'd3, 3'd0, 8'h04, 4'd3, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 4'd0, 3'd0, 8'h04, 4'd3, 1));
        tbl.push_back(v(0, 8'h29, 0, 0, 4'd0, 3'd0, 8'h2D, 4'd3, 1));
        tbl.push_back(v(0, 8'h00, 1, 0, 4'd0, 3'd0, 8'h2C, 4'd1, 1));
        tbl.push_back(v(0, 8'h00, 1, 0, 4'd0, 3'd0, 8'h28, 4'd3, 1));
        tbl.push_back(v(0, 8'h01, 1, 1, 4'd1, 3'd0, 8'h21, 4'd4, 1));
        tbl.push_back(v(0, 8'h00, 1, 0, 4'd0, 3'd0, 8'h20, 4'd1, 1));
        tbl.push_back(v(0, 8'h00, 1, 0, 4'd0, 3'd0, 8'h00, 4'd6, 1));
        tbl.push_back(v(0, 8'h00, 1, 0, 4'd0, 3'd0, 8'h00, 4'd0, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 4'd0, 3'd0, 8'h00, 4'd0, 0));
        tbl.push_back(v(0, 8'hC2, 0, 0, 4'd0, 3'd0, 8'hC2, 4'd0, 0));
        tbl.push_back(v(1, 8'h00, 0, 0, 4'd0, 3'd0, 8'h00, 4'd0, 0));
        tbl.push_back(v(0, 8'h01, 0, 1, 4'd1, 3'd0, 8'h01, 4'd0, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 4'd0, 3'd0, 8'h01, 4'd0, 1));
        tbl.push_back(v(0, 8'h00, 1, 0, 4'd0, 3'd0, 8'h00, 4'd1, 1));

        foreach (tbl[i]) step(tbl[i]);

`ifdef PLIC_PRIORITY_EN
        // Priority order with a tie: indices 1,4,6 at prio 2,5,5.
        bus.prio = '0;
        bus.prio[1*PW +: PW] = PW'(2);
        bus.prio[4*PW +: PW] = PW'(5);
        bus.prio[6*PW +: PW] = PW'(5);
        step(v(1, 8'h00, 0, 0, 4'd0, 3'd0, 8'h00, 4'd0, 0));
        step(v(0, 8'h52, 0, 0, 4'd0, 3'd0, 8'h52, 4'd0, 0));
        step(v(0, 8'h00, 0, 0, 4'd0, 3'd0, 8'h52, 4'd0, 1));
        step(v(0, 8'h00, 1, 0, 4'd0, 3'd0, 8'h42, 4'd5, 1));
        step(v(0, 8'h00, 1, 0, 4'd0, 3'd0, 8'h02, 4'd7, 1));
        step(v(0, 8'h00, 1, 0, 4'd0, 3'd0, 8'h00, 4'd2, 1));
        step(v(0, 8'h00, 0, 0, 4'd0, 3'd0, 8'h00, 4'd2, 0));

        // Threshold masks eip but not the claim.
        bus.prio = '0;
        bus.prio[0 +: PW] = PW'(2);
        step(v(1, 8'h00, 0, 0, 4'd0, 3'd2, 8'h00, 4'd0, 0));
        step(v(0, 8'h01, 0, 0, 4'd0, 3'd2, 8'h01, 4'd0, 0));
        step(v(0, 8'h00, 0, 0, 4'd0, 3'd2, 8'h01, 4'd0, 0));
        step(v(0, 8'h00, 0, 0, 4'd0, 3'd1, 8'h01, 4'd0, 1));
        step(v(0, 8'h00, 1, 0, 4'd0, 3'd2, 8'h00, 4'd1, 0));
`else
        // Priority-0 sources still arbitrate when priority is compiled out.
        bus.prio = '0;
        step(v(1, 8'h00, 0, 0, 4'd0, 3'd0, 8'h00, 4'd0, 0));
        step(v(0, 8'h09, 0, 0, 4'd0, 3'd0, 8'h09, 4'd0, 0));
        step(v(0, 8'h00, 0, 0, 4'd0, 3'd0, 8'h09, 4'd0, 1));
        step(v(0, 8'h00, 1, 0, 4'd0, 3'd0, 8'h08, 4'd1, 1));
        step(v(0, 8'h00, 1, 0, 4'd0, 3'd0, 8'h00, 4'd4, 1));
        step(v(0, 8'h00, 0, 0, 4'd0, 3'd0, 8'h00, 4'd4, 0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
